// File: rtl/pipeline_ctrl_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_hazard_unit
//
// Purpose:
//   ID-stage control decode for the 5-stage ARM64 pipeline. It also holds:
//   - the registered ID/EX control bundle,
//   - the architectural NZVC flag register, with EX-to-ID flag forwarding,
//   - load-use stall detection,
//   - branch resolution, with an optional IF/ID flush.
//   The datapath consumes only the ex_* outputs.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   opcode_id             instr[31:21] of the instruction in ID
//   rn_id, rm_id, rt_id   register fields of the instruction in ID
//   cbz_zero_id           forwarded Rt==0 compare result for CBZ
//   alu_n/z/v/c           flags produced by the ALU this cycle (instruction in EX)
//   stall_if              hold PC and IF/ID (combinational)
//   flush_if_id           zero IF/ID on the next edge (combinational)
//   br_taken_id           select branch target PC (combinational)
//   cond_br_id            1: CondAddr19 offset, 0: BrAddr26 offset (combinational)
//   ex_*                  registered ID/EX control bundle and destination index
//   flag_n/z/v/c          architectural flag register
// -----------------------------------------------------------------------------
module pipeline_ctrl_hazard_unit #(
    parameter int OPC_W         = 11,
    parameter int REG_W         = 5,
    parameter int ALUOP_W       = 3,
    parameter int BR_DELAY_SLOT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC_W-1:0]   opcode_id,
    input  logic [REG_W-1:0]   rn_id,
    input  logic [REG_W-1:0]   rm_id,
    input  logic [REG_W-1:0]   rt_id,
    input  logic               cbz_zero_id,
    input  logic               alu_n,
    input  logic               alu_z,
    input  logic               alu_v,
    input  logic               alu_c,
    output logic               stall_if,
    output logic               flush_if_id,
    output logic               br_taken_id,
    output logic               cond_br_id,
    output logic               ex_reg2loc,
    output logic               ex_addi,
    output logic               ex_setflag,
    output logic               ex_alusrc,
    output logic               ex_memwrite,
    output logic               ex_lsr2reg,
    output logic               ex_mem2reg,
    output logic               ex_regwrite,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [REG_W-1:0]   ex_rd,
    output logic               ex_illegal,
    output logic               flag_n,
    output logic               flag_z,
    output logic               flag_v,
    output logic               flag_c
);

    // Index of the zero register; writes to it never create a hazard.
    localparam logic [REG_W-1:0] XZR = {REG_W{1'b1}};

    typedef struct packed {
        logic               reg2loc;
        logic               addi;
        logic               setflag;
        logic               alusrc;
        logic               memwrite;
        logic               lsr2reg;
        logic               mem2reg;
        logic               regwrite;
        logic [ALUOP_W-1:0] aluop;
        logic               illegal;
    } ctrl_t;

    ctrl_t            dec_s;
    logic             is_b_s;
    logic             is_blt_s;
    logic             is_cbz_s;
    logic             uses_rn_s;
    logic             uses_r2_s;
    logic [REG_W-1:0] r2_s;
    logic             hit_rn_s;
    logic             hit_r2_s;
    logic             stall_s;
    logic             lt_s;
    logic             br_raw_s;
    logic             cond_s;
    logic             br_taken_s;
    logic             flush_s;

    ctrl_t            ex_r;
    logic [REG_W-1:0] ex_rd_r;
    logic [3:0]       flags_r;   // {n, z, v, c}

    // Opcode decode into the control bundle and the register-usage flags.
    always_comb begin
        dec_s     = '0;
        is_b_s    = 1'b0;
        is_blt_s  = 1'b0;
        is_cbz_s  = 1'b0;
        uses_rn_s = 1'b0;
        uses_r2_s = 1'b0;
        casez (opcode_id)
            11'b11111000000: begin // STUR
                dec_s.reg2loc  = 1'b1;
                dec_s.alusrc   = 1'b1;
                dec_s.memwrite = 1'b1;
                dec_s.aluop    = ALUOP_W'(3'b010);
                uses_rn_s      = 1'b1;
                uses_r2_s      = 1'b1;
            end
            11'b11111000010: begin // LDUR
                dec_s.alusrc   = 1'b1;
                dec_s.mem2reg  = 1'b1;
                dec_s.regwrite = 1'b1;
                dec_s.aluop    = ALUOP_W'(3'b010);
                uses_rn_s      = 1'b1;
            end
            11'b1001000100?: begin // ADDI
                dec_s.addi     = 1'b1;
                dec_s.alusrc   = 1'b1;
                dec_s.regwrite = 1'b1;
                dec_s.aluop    = ALUOP_W'(3'b010);
                uses_rn_s      = 1'b1;
            end
            11'b10101011000: begin // ADDS
                dec_s.setflag  = 1'b1;
                dec_s.regwrite = 1'b1;
                dec_s.aluop    = ALUOP_W'(3'b010);
                uses_rn_s      = 1'b1;
                uses_r2_s      = 1'b1;
            end
            11'b11101011000: begin // SUBS
                dec_s.setflag  = 1'b1;
                dec_s.regwrite = 1'b1;
                dec_s.aluop    = ALUOP_W'(3'b011);
                uses_rn_s      = 1'b1;
                uses_r2_s      = 1'b1;
            end
            11'b10001010000: begin // AND
                dec_s.regwrite = 1'b1;
                dec_s.aluop    = ALUOP_W'(3'b100);
                uses_rn_s      = 1'b1;
                uses_r2_s      = 1'b1;
            end
            11'b11001010000: begin // EOR
                dec_s.regwrite = 1'b1;
                dec_s.aluop    = ALUOP_W'(3'b110);
                uses_rn_s      = 1'b1;
                uses_r2_s      = 1'b1;
            end
            11'b11010011010: begin // LSR
                dec_s.lsr2reg  = 1'b1;
                dec_s.regwrite = 1'b1;
                uses_rn_s      = 1'b1;
            end
            11'b000101?????: begin // B
                is_b_s = 1'b1;
            end
            11'b01010100???: begin // B.LT
                is_blt_s = 1'b1;
            end
            11'b10110100???: begin // CBZ
                dec_s.reg2loc = 1'b1;
                is_cbz_s      = 1'b1;
                uses_rn_s     = 1'b1;
                uses_r2_s     = 1'b1;
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
    end

    // Load-use hazard: a load in EX whose destination feeds the ID instruction.
    always_comb begin
        if (dec_s.reg2loc) begin
            r2_s = rt_id;
        end else begin
            r2_s = rm_id;
        end
        hit_rn_s = uses_rn_s & (ex_r.mem2reg ? (ex_rd_r == rn_id) : 1'b0);
        hit_r2_s = uses_r2_s & (ex_rd_r == r2_s);
        stall_s  = ex_r.mem2reg & ex_r.regwrite & (ex_rd_r != XZR) & (hit_rn_s | hit_r2_s);
    end

    // Branch resolution. LT comes from the ALU when EX is setting flags this cycle.
    always_comb begin
        if (ex_r.setflag) begin
            lt_s = alu_n ^ alu_v;
        end else begin
            lt_s = flags_r[3] ^ flags_r[1];
        end

        br_raw_s = 1'b0;
        cond_s   = 1'b0;
        if (is_b_s) begin
            br_raw_s = 1'b1;
            cond_s   = 1'b0;
        end else if (is_blt_s) begin
            br_raw_s = lt_s;
            cond_s   = 1'b1;
        end else if (is_cbz_s) begin
            br_raw_s = cbz_zero_id;
            cond_s   = 1'b1;
        end else begin
            br_raw_s = 1'b0;
            cond_s   = 1'b0;
        end

        // A stalled branch re-resolves next cycle once its operands are forwarded.
        if (stall_s) begin
            br_taken_s = 1'b0;
        end else begin
            br_taken_s = br_raw_s;
        end

        if (BR_DELAY_SLOT != 0) begin
            flush_s = 1'b0;
        end else begin
            flush_s = br_taken_s;
        end
    end

    // ID/EX control register; a stall inserts an all-zero bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_r    <= '0;
            ex_rd_r <= '0;
        end else if (stall_s) begin
            ex_r    <= '0;
            ex_rd_r <= '0;
        end else begin
            ex_r    <= dec_s;
            ex_rd_r <= rt_id;
        end
    end

    // Architectural NZVC register, written by flag-setting instructions in EX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= 4'b0000;
        end else if (ex_r.setflag) begin
            flags_r <= {alu_n, alu_z, alu_v, alu_c};
        end else begin
            flags_r <= flags_r;
        end
    end

    assign stall_if    = stall_s;
    assign flush_if_id = flush_s;
    assign br_taken_id = br_taken_s;
    assign cond_br_id  = cond_s;

    assign ex_reg2loc  = ex_r.reg2loc;
    assign ex_addi     = ex_r.addi;
    assign ex_setflag  = ex_r.setflag;
    assign ex_alusrc   = ex_r.alusrc;
    assign ex_memwrite = ex_r.memwrite;
    assign ex_lsr2reg  = ex_r.lsr2reg;
    assign ex_mem2reg  = ex_r.mem2reg;
    assign ex_regwrite = ex_r.regwrite;
    assign ex_aluop    = ex_r.aluop;
    assign ex_illegal  = ex_r.illegal;
    assign ex_rd       = ex_rd_r;

    assign flag_n = flags_r[3];
    assign flag_z = flags_r[2];
    assign flag_v = flags_r[1];
    assign flag_c = flags_r[0];

endmodule

// File: tb/tb_pipeline_ctrl_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl_hazard_unit
//
// Directed bench for pipeline_ctrl_hazard_unit. Two instances share the same
// inputs: dut is built with BR_DELAY_SLOT=0 and dut_ds with BR_DELAY_SLOT=1.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl_hazard_unit;

    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_BLT  = 11'b01010100000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;

    // Bundle order: reg2loc,addi,setflag,alusrc,memwrite,lsr2reg,mem2reg,regwrite,aluop[2:0]
    localparam logic [10:0] EXP_ADDS = 11'b00100001010;
    localparam logic [10:0] EXP_SUBS = 11'b00100001011;

    logic       clk;
    logic       reset;
    logic [10:0] opcode_id;
    logic [4:0] rn_id;
    logic [4:0] rm_id;
    logic [4:0] rt_id;
    logic       cbz_zero_id;
    logic       alu_n, alu_z, alu_v, alu_c;

    logic       stall_if, flush_if_id, br_taken_id, cond_br_id;
    logic       ex_reg2loc, ex_addi, ex_setflag, ex_alusrc, ex_memwrite;
    logic       ex_lsr2reg, ex_mem2reg, ex_regwrite, ex_illegal;
    logic [2:0] ex_aluop;
    logic [4:0] ex_rd;
    logic       flag_n, flag_z, flag_v, flag_c;

    logic       ds_stall_if, ds_flush_if_id, ds_br_taken_id, ds_cond_br_id;
    logic       ds_reg2loc, ds_addi, ds_setflag, ds_alusrc, ds_memwrite;
    logic       ds_lsr2reg, ds_mem2reg, ds_regwrite, ds_illegal;
    logic [2:0] ds_aluop;
    logic [4:0] ds_rd;
    logic       ds_flag_n, ds_flag_z, ds_flag_v, ds_flag_c;

    logic [10:0] ex_bus;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    assign ex_bus = {ex_reg2loc, ex_addi, ex_setflag, ex_alusrc, ex_memwrite,
                     ex_lsr2reg, ex_mem2reg, ex_regwrite, ex_aluop};
    assign flags  = {flag_n, flag_z, flag_v, flag_c};

    pipeline_ctrl_hazard_unit #(.BR_DELAY_SLOT(0)) dut (
        .clk(clk), .reset(reset), .opcode_id(opcode_id),
        .rn_id(rn_id), .rm_id(rm_id), .rt_id(rt_id), .cbz_zero_id(cbz_zero_id),
        .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .stall_if(stall_if), .flush_if_id(flush_if_id),
        .br_taken_id(br_taken_id), .cond_br_id(cond_br_id),
        .ex_reg2loc(ex_reg2loc), .ex_addi(ex_addi), .ex_setflag(ex_setflag),
        .ex_alusrc(ex_alusrc), .ex_memwrite(ex_memwrite), .ex_lsr2reg(ex_lsr2reg),
        .ex_mem2reg(ex_mem2reg), .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
        .ex_rd(ex_rd), .ex_illegal(ex_illegal),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c)
    );

    pipeline_ctrl_hazard_unit #(.BR_DELAY_SLOT(1)) dut_ds (
        .clk(clk), .reset(reset), .opcode_id(opcode_id),
        .rn_id(rn_id), .rm_id(rm_id), .rt_id(rt_id), .cbz_zero_id(cbz_zero_id),
        .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .stall_if(ds_stall_if), .flush_if_id(ds_flush_if_id),
        .br_taken_id(ds_br_taken_id), .cond_br_id(ds_cond_br_id),
        .ex_reg2loc(ds_reg2loc), .ex_addi(ds_addi), .ex_setflag(ds_setflag),
        .ex_alusrc(ds_alusrc), .ex_memwrite(ds_memwrite), .ex_lsr2reg(ds_lsr2reg),
        .ex_mem2reg(ds_mem2reg), .ex_regwrite(ds_regwrite), .ex_aluop(ds_aluop),
        .ex_rd(ds_rd), .ex_illegal(ds_illegal),
        .flag_n(ds_flag_n), .flag_z(ds_flag_z), .flag_v(ds_flag_v), .flag_c(ds_flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [10:0] opc, input logic [4:0] rn,
                          input logic [4:0] rm, input logic [4:0] rt);
        opcode_id = opc;
        rn_id     = rn;
        rm_id     = rm;
        rt_id     = rt;
    endtask

    task automatic set_alu(input logic [3:0] nzvc);
        {alu_n, alu_z, alu_v, alu_c} = nzvc;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_id(OP_ADDS, 5'd1, 5'd2, 5'd3);
        cbz_zero_id = 1'b0;
        set_alu(4'b1111);
        tick();
        tick();
        checks++;
        if (ex_bus !== 11'd0 || ex_rd !== 5'd0 || ex_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_ex: got bus=%b rd=%0d ill=%b, want 0", ex_bus, ex_rd, ex_illegal);
        end
        checks++;
        if (flags !== 4'b0000 || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got flags=%b stall=%b, want 0000/0", flags, stall_if);
        end
        set_alu(4'b0000);
        reset = 1'b0;
    endtask

    task automatic test_decode;
        logic [10:0] opc [14];
        logic [10:0] exp [14];
        logic        ill [14];
        opc = '{OP_STUR, OP_LDUR, OP_ADDI, 11'b10010001001, OP_ADDS, OP_SUBS, OP_AND,
                OP_EOR, OP_LSR, OP_B, OP_BLT, OP_CBZ, 11'h000, 11'h7FF};
        exp = '{11'b10011000010, 11'b00010011010, 11'b01010001010, 11'b01010001010,
                EXP_ADDS, EXP_SUBS, 11'b00000001100, 11'b00000001110, 11'b00000101000,
                11'b00000000000, 11'b00000000000, 11'b10000000000, 11'b00000000000,
                11'b00000000000};
        ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b1};
        set_alu(4'b0000);
        for (int i = 0; i < 14; i++) begin
            set_id(opc[i], 5'd1, 5'd2, 5'(4 + i));
            tick();
            checks++;
            if (ex_bus !== exp[i] || ex_illegal !== ill[i] || ex_rd !== 5'(4 + i)) begin
                errors++;
                $display("FAIL decode[%0d] opc=%b: got bus=%b ill=%b rd=%0d, want bus=%b ill=%b rd=%0d",
                         i, opc[i], ex_bus, ex_illegal, ex_rd, exp[i], ill[i], 4 + i);
            end
        end
    endtask

    task automatic test_flag_forward;
        set_alu(4'b0000);
        set_id(OP_ADDS, 5'd1, 5'd2, 5'd5);
        tick();
        // ADDS in EX produces N=1, V=0; B.LT in ID must see LT through forwarding.
        set_alu(4'b1000);
        set_id(OP_BLT, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (br_taken_id !== 1'b1 || cond_br_id !== 1'b1 || flush_if_id !== 1'b1) begin
            errors++;
            $display("FAIL blt_fwd: got br=%b cond=%b flush=%b, want 1/1/1", br_taken_id, cond_br_id, flush_if_id);
        end
        checks++;
        if (ds_br_taken_id !== 1'b1 || ds_flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL blt_fwd_ds: got br=%b flush=%b, want 1/0", ds_br_taken_id, ds_flush_if_id);
        end
        tick();
        checks++;
        if (flags !== 4'b1000) begin
            errors++;
            $display("FAIL flags_load: got %b, want 1000", flags);
        end
        // EX now holds B.LT (no flag set), so LT comes from the register.
        set_alu(4'b0000);
        #1;
        checks++;
        if (br_taken_id !== 1'b1) begin
            errors++;
            $display("FAIL blt_reg: got br=%b, want 1", br_taken_id);
        end
        set_id(OP_ADDS, 5'd1, 5'd2, 5'd5);
        tick();
        set_alu(4'b1111);
        set_id(OP_BLT, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (br_taken_id !== 1'b0 || flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL blt_not_lt: got br=%b flush=%b, want 0/0", br_taken_id, flush_if_id);
        end
        tick();
        checks++;
        if (flags !== 4'b1111) begin
            errors++;
            $display("FAIL flags_load2: got %b, want 1111", flags);
        end
        set_alu(4'b0000);
        set_id(OP_AND, 5'd1, 5'd2, 5'd3);
        tick();
        checks++;
        if (flags !== 4'b1111) begin
            errors++;
            $display("FAIL flags_hold: got %b, want 1111", flags);
        end
    endtask

    task automatic test_load_use;
        set_alu(4'b0000);
        cbz_zero_id = 1'b0;
        // Rn match: LDUR X3 then ADDS X5,X3,X4.
        set_id(OP_LDUR, 5'd1, 5'd2, 5'd3);
        tick();
        set_id(OP_ADDS, 5'd3, 5'd4, 5'd5);
        #1;
        checks++;
        if (stall_if !== 1'b1) begin
            errors++;
            $display("FAIL lu_rn_stall: got %b, want 1", stall_if);
        end
        tick();
        checks++;
        if (ex_bus !== 11'd0 || ex_rd !== 5'd0 || ex_illegal !== 1'b0 || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL lu_bubble: got bus=%b rd=%0d ill=%b stall=%b, want 0/0/0/0",
                     ex_bus, ex_rd, ex_illegal, stall_if);
        end
        tick();
        checks++;
        if (ex_bus !== EXP_ADDS || ex_rd !== 5'd5) begin
            errors++;
            $display("FAIL lu_issue: got bus=%b rd=%0d, want %b/5", ex_bus, ex_rd, EXP_ADDS);
        end
        // Rm match: LDUR X4 then SUBS X6,X1,X4.
        set_id(OP_LDUR, 5'd1, 5'd2, 5'd4);
        tick();
        set_id(OP_SUBS, 5'd1, 5'd4, 5'd6);
        #1;
        checks++;
        if (stall_if !== 1'b1) begin
            errors++;
            $display("FAIL lu_rm_stall: got %b, want 1", stall_if);
        end
        tick();
        tick();
        checks++;
        if (ex_bus !== EXP_SUBS || ex_rd !== 5'd6) begin
            errors++;
            $display("FAIL lu_rm_issue: got bus=%b rd=%0d, want %b/6", ex_bus, ex_rd, EXP_SUBS);
        end
        // Rt match through Reg2Loc on CBZ; stall must suppress the branch.
        set_id(OP_LDUR, 5'd1, 5'd2, 5'd7);
        tick();
        set_id(OP_CBZ, 5'd0, 5'd0, 5'd7);
        cbz_zero_id = 1'b1;
        #1;
        checks++;
        if (stall_if !== 1'b1 || br_taken_id !== 1'b0 || flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL lu_cbz_stall: got stall=%b br=%b flush=%b, want 1/0/0",
                     stall_if, br_taken_id, flush_if_id);
        end
        tick();
        checks++;
        if (stall_if !== 1'b0 || br_taken_id !== 1'b1 || flush_if_id !== 1'b1) begin
            errors++;
            $display("FAIL lu_cbz_resolve: got stall=%b br=%b flush=%b, want 0/1/1",
                     stall_if, br_taken_id, flush_if_id);
        end
        tick();
        cbz_zero_id = 1'b0;
        // ADDI does not read Rm, so a matching Rm field is harmless.
        set_id(OP_LDUR, 5'd1, 5'd2, 5'd8);
        tick();
        set_id(OP_ADDI, 5'd9, 5'd8, 5'd10);
        #1;
        checks++;
        if (stall_if !== 1'b0) begin
            errors++;
            $display("FAIL lu_addi_rm: got %b, want 0", stall_if);
        end
        // Load into XZR never stalls.
        set_id(OP_LDUR, 5'd1, 5'd2, 5'd31);
        tick();
        set_id(OP_ADDS, 5'd31, 5'd31, 5'd5);
        #1;
        checks++;
        if (stall_if !== 1'b0) begin
            errors++;
            $display("FAIL lu_xzr: got %b, want 0", stall_if);
        end
        tick();
    endtask

    task automatic test_branch;
        set_id(OP_CBZ, 5'd0, 5'd0, 5'd3);
        cbz_zero_id = 1'b1;
        #1;
        checks++;
        if (br_taken_id !== 1'b1 || cond_br_id !== 1'b1 || flush_if_id !== 1'b1) begin
            errors++;
            $display("FAIL cbz_taken: got br=%b cond=%b flush=%b, want 1/1/1", br_taken_id, cond_br_id, flush_if_id);
        end
        checks++;
        if (ds_br_taken_id !== 1'b1 || ds_flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL cbz_taken_ds: got br=%b flush=%b, want 1/0", ds_br_taken_id, ds_flush_if_id);
        end
        cbz_zero_id = 1'b0;
        #1;
        checks++;
        if (br_taken_id !== 1'b0 || flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL cbz_not_taken: got br=%b flush=%b, want 0/0", br_taken_id, flush_if_id);
        end
        set_id(OP_B, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (br_taken_id !== 1'b1 || cond_br_id !== 1'b0) begin
            errors++;
            $display("FAIL b_uncond: got br=%b cond=%b, want 1/0", br_taken_id, cond_br_id);
        end
        set_id(OP_ADDS, 5'd1, 5'd2, 5'd3);
        #1;
        checks++;
        if (br_taken_id !== 1'b0 || cond_br_id !== 1'b0) begin
            errors++;
            $display("FAIL non_branch: got br=%b cond=%b, want 0/0", br_taken_id, cond_br_id);
        end
    endtask

    task automatic test_illegal;
        set_id(11'h000, 5'd1, 5'd2, 5'd3);
        tick();
        checks++;
        if (ex_illegal !== 1'b1 || ex_regwrite !== 1'b0 || ex_memwrite !== 1'b0) begin
            errors++;
            $display("FAIL illegal: got ill=%b rw=%b mw=%b, want 1/0/0", ex_illegal, ex_regwrite, ex_memwrite);
        end
    endtask

    task automatic test_reset_mid;
        set_alu(4'b1111);
        set_id(OP_ADDS, 5'd1, 5'd2, 5'd9);
        tick();
        tick();
        checks++;
        if (flags !== 4'b1111 || ex_bus !== EXP_ADDS || ex_rd !== 5'd9) begin
            errors++;
            $display("FAIL pre_reset: got flags=%b bus=%b rd=%0d, want 1111/%b/9", flags, ex_bus, ex_rd, EXP_ADDS);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (ex_bus !== 11'd0 || ex_rd !== 5'd0 || ex_illegal !== 1'b0 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async: got bus=%b rd=%0d ill=%b flags=%b, want all 0",
                     ex_bus, ex_rd, ex_illegal, flags);
        end
        #1;
        reset = 1'b0;
        set_alu(4'b0000);
        tick();
        checks++;
        if (ex_bus !== EXP_ADDS || flags !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset: got bus=%b flags=%b, want %b/0000", ex_bus, flags, EXP_ADDS);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_flag_forward();
        test_load_use();
        test_branch();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
